// File: rtl/digit_scanner.sv
// Time-multiplexed display scanner: rotates a one-hot digit select at a programmable
// rate, with per-digit decimal point, leading-zero blanking and a per-frame snapshot.
module digit_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] value,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          blank_lz,
  output logic [NUM_DIGITS-1:0]         sel,
  output logic [DIGIT_W-1:0]            digit,
  output logic                          dp,
  output logic                          blank,
  output logic                          tick
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]              r_pre;
  logic [IDX_W-1:0]              r_idx;
  logic [NUM_DIGITS*DIGIT_W-1:0] r_snap;
  logic [NUM_DIGITS-1:0]         r_snap_dp;
  logic [NUM_DIGITS-1:0]         r_sel;
  logic [DIGIT_W-1:0]            r_digit;
  logic                          r_dp;
  logic                          r_blank;
  logic                          r_tick;

  logic                          w_terminal;
  logic [NUM_DIGITS-1:0]         w_upper_zero;
  logic                          w_acc;
  logic [DIGIT_W-1:0]            w_cur_digit;
  logic                          w_cur_dp;
  logic                          w_blank;

  assign w_terminal  = en && (r_pre == PRE_LAST);
  assign w_cur_digit = r_snap[r_idx*DIGIT_W +: DIGIT_W];
  assign w_cur_dp    = r_snap_dp[r_idx];

  // w_upper_zero[i] is set when snapshot digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    w_acc        = 1'b1;
    w_upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_acc           = w_acc & (r_snap[i*DIGIT_W +: DIGIT_W] == '0);
      w_upper_zero[i] = w_acc;
    end
  end

  assign w_blank = blank_lz && (r_idx != '0) && w_upper_zero[r_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_terminal;
      if (w_terminal) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else if (en) begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // The snapshot only follows the input during slot 0, so a frame never mixes samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap    <= '0;
      r_snap_dp <= '0;
    end else if (r_idx == '0) begin
      r_snap    <= value;
      r_snap_dp <= dp_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel   <= '0;
      r_digit <= '0;
      r_dp    <= 1'b0;
      r_blank <= 1'b0;
    end else begin
      r_sel   <= NUM_DIGITS'(1) << r_idx;
      r_digit <= w_cur_digit;
      r_dp    <= w_cur_dp;
      r_blank <= w_blank;
    end
  end

  assign sel   = r_sel;
  assign digit = r_digit;
  assign dp    = r_dp;
  assign blank = r_blank;
  assign tick  = r_tick;

endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner: a 4-digit/4-cycle instance and an 8-digit/1-cycle
// instance, with expected per-cycle outputs queued ahead and compared as they appear.
module tb_digit_scanner;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  sel;
  logic [3:0]  digit;
  logic        dp, blank, tick;

  logic        reset8, en8;
  logic [31:0] value8;
  logic [7:0]  sel8;
  logic [3:0]  digit8;
  logic        dp8, blank8, tick8;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  digit_scanner #(.NUM_DIGITS(4), .DIGIT_W(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .sel(sel), .digit(digit), .dp(dp), .blank(blank), .tick(tick)
  );

  digit_scanner #(.NUM_DIGITS(8), .DIGIT_W(4), .REFRESH_DIV(1)) dut8 (
    .clk(clk), .reset(reset8), .en(en8), .value(value8), .dp_in(8'h00),
    .blank_lz(1'b0), .sel(sel8), .digit(digit8), .dp(dp8), .blank(blank8), .tick(tick8)
  );

  function automatic logic [W-1:0] pack(logic tk, logic bl, logic d, logic [3:0] dg,
                                        logic [7:0] s);
    return {1'b0, tk, bl, d, dg, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue n cycles of one slot; tick is expected only on the last of them when tk_last.
  task automatic push(input int n, input logic [7:0] s, input logic [3:0] dg,
                      input logic d, input logic bl, input logic tk_last);
    for (int i = 0; i < n; i++)
      exp_q.push_back(pack(tk_last && (i == n - 1), bl, d, dg, s));
  endtask

  task automatic run(input int n, input string tag, input bit use8);
    logic [W-1:0] obs;
    logic [W-1:0] expv;
    for (int i = 0; i < n; i++) begin
      step();
      obs = use8 ? pack(tick8, blank8, dp8, digit8, sel8)
                 : pack(tick, blank, dp, digit, {4'b0000, sel});
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL %s cycle %0d: observed %h but no expectation queued", tag, i, obs);
      end else begin
        expv = exp_q.pop_front();
        assert (obs === expv) else begin
          errors++;
          $error("FAIL %s cycle %0d: observed %h expected %h", tag, i, obs, expv);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b1; blank_lz = 1'b0; value = 16'h1234; dp_in = 4'b0000;
    reset8 = 1'b1; en8 = 1'b1; value8 = 32'h87654321;

    // Reset held: everything dark.
    push(3, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    run(3, "reset", 1'b0);
    reset = 1'b0;

    // Scan of 1234; first cycle shows the reset snapshot.
    push(1, 8'h01, 4'h0, 1'b0, 1'b0, 1'b0);
    push(3, 8'h01, 4'h4, 1'b0, 1'b0, 1'b1);
    push(4, 8'h02, 4'h3, 1'b0, 1'b0, 1'b1);
    push(4, 8'h04, 4'h2, 1'b0, 1'b0, 1'b1);
    push(4, 8'h08, 4'h1, 1'b0, 1'b0, 1'b1);
    push(4, 8'h01, 4'h4, 1'b0, 1'b0, 1'b1);
    run(20, "scan", 1'b0);

    // Snapshot: change value and dp mid-frame while sel=0100.
    push(4, 8'h02, 4'h3, 1'b0, 1'b0, 1'b1);
    push(1, 8'h04, 4'h2, 1'b0, 1'b0, 1'b0);
    run(5, "snap_pre", 1'b0);
    value = 16'hABCD; dp_in = 4'b0010;
    push(3, 8'h04, 4'h2, 1'b0, 1'b0, 1'b1);
    push(4, 8'h08, 4'h1, 1'b0, 1'b0, 1'b1);
    push(1, 8'h01, 4'h4, 1'b0, 1'b0, 1'b0);
    push(3, 8'h01, 4'hD, 1'b0, 1'b0, 1'b1);
    push(4, 8'h02, 4'hC, 1'b1, 1'b0, 1'b1);
    push(4, 8'h04, 4'hB, 1'b0, 1'b0, 1'b1);
    push(4, 8'h08, 4'hA, 1'b0, 1'b0, 1'b1);
    run(23, "snap", 1'b0);

    // Leading-zero blanking on 0050.
    blank_lz = 1'b1; value = 16'h0050; dp_in = 4'b0000;
    push(1, 8'h01, 4'hD, 1'b0, 1'b0, 1'b0);
    push(3, 8'h01, 4'h0, 1'b0, 1'b0, 1'b1);
    push(4, 8'h02, 4'h5, 1'b0, 1'b0, 1'b1);
    push(4, 8'h04, 4'h0, 1'b0, 1'b1, 1'b1);
    push(4, 8'h08, 4'h0, 1'b0, 1'b1, 1'b1);
    run(16, "blank_0050", 1'b0);

    // All-zero value: only digit 0 lit.
    value = 16'h0000;
    push(4, 8'h01, 4'h0, 1'b0, 1'b0, 1'b1);
    push(4, 8'h02, 4'h0, 1'b0, 1'b1, 1'b1);
    push(4, 8'h04, 4'h0, 1'b0, 1'b1, 1'b1);
    push(4, 8'h08, 4'h0, 1'b0, 1'b1, 1'b1);
    run(16, "blank_zero", 1'b0);

    // Blanking disabled.
    blank_lz = 1'b0;
    push(4, 8'h01, 4'h0, 1'b0, 1'b0, 1'b1);
    push(4, 8'h02, 4'h0, 1'b0, 1'b0, 1'b1);
    push(4, 8'h04, 4'h0, 1'b0, 1'b0, 1'b1);
    push(4, 8'h08, 4'h0, 1'b0, 1'b0, 1'b1);
    run(16, "blank_off", 1'b0);

    // Hold: drop en two cycles into the sel=0010 slot.
    value = 16'h1234;
    push(1, 8'h01, 4'h0, 1'b0, 1'b0, 1'b0);
    push(3, 8'h01, 4'h4, 1'b0, 1'b0, 1'b1);
    push(2, 8'h02, 4'h3, 1'b0, 1'b0, 1'b0);
    run(6, "pre_hold", 1'b0);
    en = 1'b0;
    push(10, 8'h02, 4'h3, 1'b0, 1'b0, 1'b0);
    run(10, "hold", 1'b0);
    en = 1'b1;
    push(2, 8'h02, 4'h3, 1'b0, 1'b0, 1'b1);
    push(2, 8'h04, 4'h2, 1'b0, 1'b0, 1'b0);
    run(4, "resume", 1'b0);

    // Reset mid-slot, then restart at digit 0.
    reset = 1'b1;
    push(2, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    run(2, "mid_reset", 1'b0);
    reset = 1'b0;
    push(1, 8'h01, 4'h0, 1'b0, 1'b0, 1'b0);
    push(1, 8'h01, 4'h4, 1'b0, 1'b0, 1'b0);
    run(2, "restart", 1'b0);

    // 8 digits, one cycle per slot.
    push(1, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    run(1, "reset8", 1'b1);
    reset8 = 1'b0;
    for (int i = 0; i < 16; i++)
      push(1, 8'(1 << (i % 8)), (i == 0) ? 4'h0 : 4'((i % 8) + 1), 1'b0, 1'b0, 1'b1);
    run(16, "sweep8", 1'b1);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: observed %0d leftover expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
